pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the performance counters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 load_use_stall  input  1  load-use hazard request from the ID-stage hazard detector.
REQ-005 branch_taken  input  1  EX-stage branch/jump redirect.
REQ-006 ex_muldiv_req  input  1  ID/EX register holds a multi-cycle DIV/DIVU/REM/REMU.
REQ-007 muldiv_done  input  1  divider result valid, single-cycle pulse.
REQ-008 halt_req  input  1  ECALL/EBREAK retiring in EX.
REQ-009 pc_write  output  1  PC register enable.
REQ-010 if_id_write  output  1  IF/ID register enable.
REQ-011 if_id_flush  output  1  IF/ID register cleared to NOP.
REQ-012 id_ex_bubble  output  1  ID/EX control bits zeroed.
REQ-013 id_ex_hold  output  1  ID/EX register holds its value.
REQ-014 ex_mem_bubble  output  1  EX/MEM control bits zeroed.
REQ-015 muldiv_start  output  1  one-cycle divider start pulse.
REQ-016 halted  output  1  core halted.
REQ-017 stall_cnt  output  CNT_W  count of cycles with pc_write=0 while not halted.
REQ-018 flush_cnt  output  CNT_W  count of branch flushes.

Function
REQ-019 FSM states: RUN, MD_WAIT, HALT; all outputs are combinational from state and inputs except the counters.
REQ-020 RUN default: pc_write=1, if_id_write=1, all other control outputs 0.
REQ-021 RUN priority: halt_req > branch_taken > ex_muldiv_req > load_use_stall.
REQ-022 RUN + halt_req: pc_write=0, if_id_write=0, id_ex_bubble=1; next state HALT.
REQ-023 RUN + branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1; load_use_stall is ignored that cycle.
REQ-024 RUN + ex_muldiv_req: muldiv_start=1, pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_bubble=1; next state MD_WAIT.
REQ-025 RUN + load_use_stall only: pc_write=0, if_id_write=0, id_ex_bubble=1; state stays RUN.
REQ-026 MD_WAIT without muldiv_done: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_bubble=1, muldiv_start=0.
REQ-027 MD_WAIT + muldiv_done: pc_write=1, if_id_write=1, id_ex_hold=0, ex_mem_bubble=0; next state RUN.
REQ-028 MD_WAIT also honours load_use_stall in its done cycle per REQ-025; it ignores branch_taken and halt_req.
REQ-029 A DIV following a DIV back-to-back re-enters MD_WAIT with a fresh muldiv_start; no start is issued in a done cycle.
REQ-030 muldiv_done in RUN or HALT is ignored.
REQ-031 HALT: pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_bubble=1, halted=1; exit only via rst.
REQ-032 stall_cnt increments by 1 on each cycle with pc_write=0 and state not HALT; saturates at all-ones.
REQ-033 flush_cnt increments by 1 on each cycle with if_id_flush=1; saturates at all-ones.

Reset
REQ-034 rst forces state RUN and clears stall_cnt and flush_cnt on the next rising edge, overriding all other inputs including mid-MD_WAIT and HALT.
REQ-035 During the reset cycle, outputs follow RUN defaults with all control inputs treated as 0.

Structure
REQ-036 State encoding (RUN=2'd0, MD_WAIT=2'd1, HALT=2'd2) resides in the shared core defines package.
REQ-037 Single flat module; the saturating counter is one sub-module, sat_counter, instantiated twice.

Verification
REQ-038 Load-use: load_use_stall=1 for one cycle -> pc_write=0, id_ex_bubble=1 that cycle, stall_cnt=1.
REQ-039 Branch plus load-use in the same cycle -> if_id_flush=1, pc_write=1, flush_cnt=1, stall_cnt=0.
REQ-040 DIV: ex_muldiv_req=1, muldiv_done after 33 cycles -> muldiv_start pulses once, holds for 34 cycles total, stall_cnt=34.
REQ-041 rst asserted 5 cycles into MD_WAIT -> next cycle state RUN, counters 0, pc_write=1.
REQ-042 halt_req=1 -> halted=1 from the next cycle onward despite branch_taken/muldiv_done; stall_cnt frozen.
REQ-043 CNT_W=4, 20 consecutive load-use stalls -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: state encoding
// and the bundle of pipeline-register control strobes.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_hold;
    logic ex_mem_bubble;
    logic muldiv_start;
    logic halted;
  } ctrl_t;

  // Free-running pipeline: fetch and decode advance, nothing squashed.
  function automatic ctrl_t ctrl_run_default();
    ctrl_t c;
    c             = '0;
    c.pc_write    = 1'b1;
    c.if_id_write = 1'b1;
    return c;
  endfunction

  // Load-use stall: freeze fetch/decode, inject a bubble into EX.
  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c              = '0;
    c.id_ex_bubble = 1'b1;
    return c;
  endfunction

  // Divider busy: freeze everything up to EX and keep MEM fed with bubbles.
  function automatic ctrl_t ctrl_md_hold();
    ctrl_t c;
    c               = '0;
    c.id_ex_hold    = 1'b1;
    c.ex_mem_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/halt controller with a multi-cycle divider wait state
// and saturating stall/flush performance counters.
//
// state      | meaning
// ST_RUN     | normal issue; resolves halt > branch > div > load-use
// ST_MD_WAIT | divider busy; pipeline frozen until muldiv_done
// ST_HALT    | ECALL/EBREAK retired; frozen until rst
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             ex_muldiv_req,
  input  logic             muldiv_done,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             ex_mem_bubble,
  output logic             muldiv_start,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t r_state;
  state_t w_state_eff;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_lu, w_br, w_md, w_dn, w_ht;
  logic   w_stall_inc;
  logic   w_flush_inc;

  // During reset the controller behaves as an idle RUN cycle.
  assign w_state_eff = rst ? ST_RUN : r_state;
  assign w_lu        = load_use_stall & ~rst;
  assign w_br        = branch_taken   & ~rst;
  assign w_md        = ex_muldiv_req  & ~rst;
  assign w_dn        = muldiv_done    & ~rst;
  assign w_ht        = halt_req       & ~rst;

  always_comb begin
    w_ctrl = ctrl_run_default();
    w_next = w_state_eff;
    case (w_state_eff)
      ST_RUN: begin
        if (w_ht) begin
          w_ctrl = ctrl_load_use();
          w_next = ST_HALT;
        end else if (w_br) begin
          w_ctrl.if_id_flush  = 1'b1;
          w_ctrl.id_ex_bubble = 1'b1;
        end else if (w_md) begin
          w_ctrl              = ctrl_md_hold();
          w_ctrl.muldiv_start = 1'b1;
          w_next              = ST_MD_WAIT;
        end else if (w_lu) begin
          w_ctrl = ctrl_load_use();
        end
      end
      ST_MD_WAIT: begin
        // A queued DIV is only started once back in RUN, never in the done cycle.
        if (!w_dn) begin
          w_ctrl = ctrl_md_hold();
        end else begin
          w_next = ST_RUN;
          if (w_lu) begin
            w_ctrl = ctrl_load_use();
          end
        end
      end
      ST_HALT: begin
        w_ctrl               = '0;
        w_ctrl.id_ex_bubble  = 1'b1;
        w_ctrl.ex_mem_bubble = 1'b1;
        w_ctrl.halted        = 1'b1;
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  assign pc_write      = w_ctrl.pc_write;
  assign if_id_write   = w_ctrl.if_id_write;
  assign if_id_flush   = w_ctrl.if_id_flush;
  assign id_ex_bubble  = w_ctrl.id_ex_bubble;
  assign id_ex_hold    = w_ctrl.id_ex_hold;
  assign ex_mem_bubble = w_ctrl.ex_mem_bubble;
  assign muldiv_start  = w_ctrl.muldiv_start;
  assign halted        = w_ctrl.halted;

  assign w_stall_inc = ~w_ctrl.pc_write & (w_state_eff != ST_HALT);
  assign w_flush_inc = w_ctrl.if_id_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall_inc),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_flush_inc),
    .o_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst, load_use_stall, branch_taken, ex_muldiv_req, muldiv_done, halt_req;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold;
  logic ex_mem_bubble, muldiv_start, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic pc_write4, if_id_write4, if_id_flush4, id_ex_bubble4, id_ex_hold4;
  logic ex_mem_bubble4, muldiv_start4, halted4;
  logic [3:0] stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .load_use_stall(load_use_stall), .branch_taken(branch_taken),
    .ex_muldiv_req(ex_muldiv_req), .muldiv_done(muldiv_done), .halt_req(halt_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble),
    .muldiv_start(muldiv_start), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .load_use_stall(load_use_stall), .branch_taken(branch_taken),
    .ex_muldiv_req(ex_muldiv_req), .muldiv_done(muldiv_done), .halt_req(halt_req),
    .pc_write(pc_write4), .if_id_write(if_id_write4), .if_id_flush(if_id_flush4),
    .id_ex_bubble(id_ex_bubble4), .id_ex_hold(id_ex_hold4), .ex_mem_bubble(ex_mem_bubble4),
    .muldiv_start(muldiv_start4), .halted(halted4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, muldiv_start, halted}
  wire [7:0] obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                    id_ex_hold, ex_mem_bubble, muldiv_start, halted};

  // Behavioural model: "divider busy" and "halted" flags plus integer counters.
  logic [7:0] m_out;
  bit m_busy, m_halt;
  int m_stall, m_flush, m_stall4;

  task automatic apply(input bit r, input bit lu, input bit br, input bit md,
                       input bit dn, input bit ht);
    bit pc, ifw, fl, bub, hold, exb, st, hl;
    rst = r; load_use_stall = lu; branch_taken = br;
    ex_muldiv_req = md; muldiv_done = dn; halt_req = ht;
    pc = 1; ifw = 1; fl = 0; bub = 0; hold = 0; exb = 0; st = 0; hl = 0;
    if (r) begin
    end else if (m_halt) begin
      pc = 0; ifw = 0; bub = 1; exb = 1; hl = 1;
    end else if (m_busy) begin
      if (!dn) begin pc = 0; ifw = 0; hold = 1; exb = 1; end
      else if (lu) begin pc = 0; ifw = 0; bub = 1; end
    end else if (ht) begin
      pc = 0; ifw = 0; bub = 1;
    end else if (br) begin
      fl = 1; bub = 1;
    end else if (md) begin
      st = 1; pc = 0; ifw = 0; hold = 1; exb = 1;
    end else if (lu) begin
      pc = 0; ifw = 0; bub = 1;
    end
    m_out = {pc, ifw, fl, bub, hold, exb, st, hl};
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_halt = 0; m_stall = 0; m_flush = 0; m_stall4 = 0;
    end else begin
      if (!m_out[7] && !m_halt) begin
        m_stall  = (m_stall  < 65535) ? m_stall  + 1 : m_stall;
        m_stall4 = (m_stall4 < 15)    ? m_stall4 + 1 : m_stall4;
      end
      if (m_out[5]) m_flush = (m_flush < 65535) ? m_flush + 1 : m_flush;
      if (!m_halt) begin
        if (m_busy) begin
          if (muldiv_done) m_busy = 0;
        end else if (halt_req) begin
          m_halt = 1;
        end else if (!branch_taken && ex_muldiv_req) begin
          m_busy = 1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 1, 1, 1);
    checks++;
    if (obs !== 8'b1100_0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 8'b1100_0000);
    end
    advance();
    apply(0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || obs !== 8'b1100_0000) begin
      errors++; $display("FAIL reset_state: got out=%b stall=%0d flush=%0d expected out=11000000 stall=0 flush=0",
                         obs, stall_cnt, flush_cnt);
    end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    apply(0, 1, 0, 0, 0, 0);
    checks++;
    if (obs !== m_out || pc_write !== 1'b0 || id_ex_bubble !== 1'b1) begin
      errors++; $display("FAIL load_use_out: got %b expected %b", obs, m_out);
    end
    advance();
    apply(0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_cnt !== 16'd1 || obs !== 8'b1100_0000) begin
      errors++; $display("FAIL load_use_cnt: got stall=%0d out=%b expected stall=1 out=11000000", stall_cnt, obs);
    end
    advance();
  endtask

  task automatic test_branch_lu();
    do_reset();
    apply(0, 1, 1, 0, 0, 0);
    checks++;
    if (obs !== m_out || if_id_flush !== 1'b1 || pc_write !== 1'b1) begin
      errors++; $display("FAIL branch_lu_out: got %b expected %b", obs, m_out);
    end
    advance();
    apply(0, 0, 0, 0, 0, 0);
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL branch_lu_cnt: got flush=%0d stall=%0d expected flush=1 stall=0", flush_cnt, stall_cnt);
    end
    advance();
  endtask

  task automatic test_div();
    int starts = 0;
    int holds = 0;
    do_reset();
    for (int c = 0; c <= 34; c++) begin
      apply(0, 0, 0, 1, (c == 34), 0);
      starts += int'(muldiv_start);
      holds  += int'(id_ex_hold);
      checks++;
      if (obs !== m_out) begin
        errors++; $display("FAIL div_cycle%0d: got %b expected %b", c, obs, m_out);
      end
      advance();
    end
    ex_muldiv_req = 0;
    checks++;
    if (starts != 1 || holds != 34 || stall_cnt !== 16'd34) begin
      errors++; $display("FAIL div_totals: got starts=%0d holds=%0d stall=%0d expected 1 34 34",
                         starts, holds, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    apply(0, 0, 0, 1, 0, 0); advance();
    for (int c = 0; c < 3; c++) begin apply(0, 0, 0, 1, 0, 0); advance(); end
    apply(0, 0, 0, 1, 1, 0);
    checks++;
    if (muldiv_start !== 1'b0 || pc_write !== 1'b1 || obs !== m_out) begin
      errors++; $display("FAIL b2b_done_cycle: got %b expected %b", obs, m_out);
    end
    advance();
    apply(0, 0, 0, 1, 0, 0);
    checks++;
    if (muldiv_start !== 1'b1 || obs !== m_out) begin
      errors++; $display("FAIL b2b_restart: got %b expected %b", obs, m_out);
    end
    advance();
    apply(0, 1, 1, 0, 1, 1);
    checks++;
    if (obs !== 8'b0001_0000 || obs !== m_out) begin
      errors++; $display("FAIL md_done_lu: got %b expected %b", obs, m_out);
    end
    advance();
  endtask

  task automatic test_rst_mid_div();
    do_reset();
    apply(0, 0, 0, 1, 0, 0); advance();
    for (int c = 0; c < 5; c++) begin apply(0, 0, 0, 0, 0, 0); advance(); end
    apply(1, 1, 1, 1, 1, 1);
    checks++;
    if (obs !== 8'b1100_0000) begin
      errors++; $display("FAIL rst_mid_div_out: got %b expected %b", obs, 8'b1100_0000);
    end
    advance();
    apply(0, 0, 0, 0, 0, 0);
    checks++;
    if (pc_write !== 1'b1 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || id_ex_hold !== 1'b0) begin
      errors++; $display("FAIL rst_mid_div_after: got out=%b stall=%0d flush=%0d expected out=11000000 counters 0",
                         obs, stall_cnt, flush_cnt);
    end
    advance();
  endtask

  task automatic test_halt();
    do_reset();
    apply(0, 0, 1, 0, 0, 1);
    checks++;
    if (obs !== m_out || halted !== 1'b0) begin
      errors++; $display("FAIL halt_entry: got %b expected %b", obs, m_out);
    end
    advance();
    for (int c = 0; c < 12; c++) begin
      apply(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (obs !== 8'b0001_0101 || stall_cnt !== 16'd1 || flush_cnt !== 16'd0) begin
        errors++; $display("FAIL halt_hold%0d: got out=%b stall=%0d flush=%0d expected out=00010101 stall=1 flush=0",
                           c, obs, stall_cnt, flush_cnt);
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 20; c++) begin apply(0, 1, 0, 0, 0, 0); advance(); end
    apply(0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd20) begin
      errors++; $display("FAIL stall_saturate: got w4=%0d w16=%0d expected 15 20", stall_cnt4, stall_cnt);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      apply(($urandom_range(59) == 0), ($urandom_range(2) == 0), ($urandom_range(3) == 0),
            ($urandom_range(2) == 0), ($urandom_range(5) == 0), ($urandom_range(39) == 0));
      checks++;
      if (obs !== m_out || stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) ||
          stall_cnt4 !== 4'(m_stall4)) begin
        errors++; $display("FAIL random%0d: got out=%b stall=%0d flush=%0d s4=%0d expected out=%b stall=%0d flush=%0d s4=%0d",
                           c, obs, stall_cnt, flush_cnt, stall_cnt4, m_out, m_stall, m_flush, m_stall4);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1; load_use_stall = 0; branch_taken = 0; ex_muldiv_req = 0; muldiv_done = 0; halt_req = 0;
    m_out = 8'b1100_0000; m_busy = 0; m_halt = 0; m_stall = 0; m_flush = 0; m_stall4 = 0;
    #1;
    test_reset();
    test_load_use();
    test_branch_lu();
    test_div();
    test_back_to_back();
    test_rst_mid_div();
    test_halt();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
